// File: rtl/axi4_id_remapper.sv
// axi4_id_remapper
// ----------------
// AXI4 ID compressor between a wide-ID master and a narrow-ID slave. Each
// direction (read, write) owns a table of SLOTS entries {tag, cnt}. A request
// either reuses the live entry already holding its wide ID or takes the
// lowest-indexed free entry. Responses look up the entry by narrow ID to
// restore the wide ID. Only ID/valid/ready/last pass through this block;
// other payload is routed by the parent, and W bypasses the block.
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   s_ar*/m_ar*, s_aw*/m_aw*        request channels (combinational path)
//   m_r*/s_r*, m_b*/s_b*            response channels (combinational path)
//   err_resp                        sticky: response to an idle or out-of-range slot
//   rd_busy / wr_busy               some read / write entry has a nonzero count
module axi4_id_remapper #(
  parameter int IN_ID_W  = 16,
  parameter int OUT_ID_W = 6,
  parameter int SLOTS    = 8,
  parameter int MAX_OUT  = 15
) (
  input  logic                CLK,
  input  logic                RST_N,
  // read request
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [IN_ID_W-1:0]  s_arid,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [OUT_ID_W-1:0] m_arid,
  // write request
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [IN_ID_W-1:0]  s_awid,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [OUT_ID_W-1:0] m_awid,
  // read response
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [OUT_ID_W-1:0] m_rid,
  input  logic                m_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [IN_ID_W-1:0]  s_rid,
  output logic                s_rlast,
  // write response
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [OUT_ID_W-1:0] m_bid,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [IN_ID_W-1:0]  s_bid,
  // status
  output logic                err_resp,
  output logic                rd_busy,
  output logic                wr_busy
);

  localparam int CW    = $clog2(MAX_OUT + 1);
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  // Direction 0 is read, direction 1 is write; both run identical tables.
  logic [1:0]          req_valid, req_ready, fwd_valid, req_accept;
  logic [1:0]          rsp_valid, rsp_ready, rsp_last, rsp_err, busy;
  logic [IN_ID_W-1:0]  req_id  [2];
  logic [OUT_ID_W-1:0] fwd_id  [2];
  logic [OUT_ID_W-1:0] rsp_id  [2];
  logic [IN_ID_W-1:0]  rsp_tag [2];
  logic                err_resp_q;

  assign req_valid = {s_awvalid, s_arvalid};
  assign req_ready = {m_awready, m_arready};
  assign rsp_valid = {m_bvalid, m_rvalid};
  assign rsp_ready = {s_bready, s_rready};
  // Every B is final; R releases only on its last beat.
  assign rsp_last  = {1'b1, m_rlast};
  assign req_id[0] = s_arid;
  assign req_id[1] = s_awid;
  assign rsp_id[0] = m_rid;
  assign rsp_id[1] = m_bid;

  for (genvar ch = 0; ch < 2; ch++) begin : g_dir
    logic [IN_ID_W-1:0] tag_q [SLOTS];
    logic [CW-1:0]      cnt_q [SLOTS];
    logic [SLOTS-1:0]   live, rsp_sel, alloc, rel;
    logic [IDX_W-1:0]   hit_idx, free_idx, sel;
    logic               found_hit, found_free, hit_full, ok, take;
    logic               rsp_live, rsp_fire;
    logic [IN_ID_W-1:0] tag_out;

    // Allocation: decided purely from registered table state, so a slot
    // released this cycle only becomes a miss candidate next cycle.
    always_comb begin
      live       = '0;
      hit_idx    = '0;
      free_idx   = '0;
      found_hit  = 1'b0;
      found_free = 1'b0;
      hit_full   = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        live[i] = (cnt_q[i] != '0);
        if (live[i] && (tag_q[i] == req_id[ch]) && !found_hit) begin
          found_hit = 1'b1;
          hit_idx   = IDX_W'(i);
          hit_full  = (cnt_q[i] == CNT_MAX);
        end
        if (!live[i] && !found_free) begin
          found_free = 1'b1;
          free_idx   = IDX_W'(i);
        end
      end
      // A live entry with the same ID must be reused to keep same-ID ordering.
      ok  = found_hit ? !hit_full : found_free;
      sel = found_hit ? hit_idx : free_idx;
    end

    assign fwd_valid[ch]  = req_valid[ch] & ok & RST_N;
    assign req_accept[ch] = req_ready[ch] & ok & RST_N;
    assign fwd_id[ch]     = OUT_ID_W'(sel);
    assign take           = req_valid[ch] & req_accept[ch];

    // Response lookup: only a live, in-range entry yields its tag; anything
    // else returns ID 0 and is reported as an error.
    always_comb begin
      rsp_sel  = '0;
      tag_out  = '0;
      rsp_live = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        rsp_sel[i] = (rsp_id[ch] == OUT_ID_W'(i)) && live[i];
        if (rsp_sel[i]) begin
          tag_out = tag_out | tag_q[i];
        end
        rsp_live = rsp_live | rsp_sel[i];
      end
    end

    assign rsp_tag[ch] = tag_out;
    assign rsp_err[ch] = rsp_valid[ch] & ~rsp_live;
    assign rsp_fire    = rsp_valid[ch] & rsp_ready[ch] & rsp_last[ch];
    assign busy[ch]    = |live;

    always_comb begin
      alloc = '0;
      rel   = '0;
      for (int i = 0; i < SLOTS; i++) begin
        alloc[i] = take && (sel == IDX_W'(i));
        rel[i]   = rsp_fire && rsp_sel[i];
      end
    end

    // Table update: simultaneous allocate and release on one entry cancel.
    // A tag is written only when a free entry is claimed.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int i = 0; i < SLOTS; i++) begin
          tag_q[i] <= '0;
          cnt_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < SLOTS; i++) begin
          if (alloc[i] && !rel[i]) begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
            if (!live[i]) begin
              tag_q[i] <= req_id[ch];
            end
          end else if (rel[i] && !alloc[i]) begin
            cnt_q[i] <= cnt_q[i] - CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_resp_q <= 1'b0;
    end else if ((rsp_err[0] & rsp_ready[0]) | (rsp_err[1] & rsp_ready[1])) begin
      err_resp_q <= 1'b1;
    end
  end

  assign s_arready = req_accept[0];
  assign m_arvalid = fwd_valid[0];
  assign m_arid    = fwd_id[0];
  assign s_awready = req_accept[1];
  assign m_awvalid = fwd_valid[1];
  assign m_awid    = fwd_id[1];

  assign s_rvalid  = m_rvalid;
  assign m_rready  = s_rready;
  assign s_rid     = rsp_tag[0];
  assign s_rlast   = m_rlast;

  assign s_bvalid  = m_bvalid;
  assign m_bready  = s_bready;
  assign s_bid     = rsp_tag[1];

  assign err_resp  = err_resp_q;
  assign rd_busy   = busy[0];
  assign wr_busy   = busy[1];

endmodule

// File: tb/tb_axi4_id_remapper.sv
// Directed bench for axi4_id_remapper: expected IDs are queued when a step is
// driven and popped when the DUT output for that step is sampled.
module tb_axi4_id_remapper;

  localparam int IN_ID_W  = 16;
  localparam int OUT_ID_W = 6;
  localparam int SLOTS    = 8;
  localparam int MAX_OUT  = 15;

  logic                CLK;
  logic                RST_N;
  logic                s_arvalid, s_arready, m_arvalid, m_arready;
  logic [IN_ID_W-1:0]  s_arid;
  logic [OUT_ID_W-1:0] m_arid;
  logic                s_awvalid, s_awready, m_awvalid, m_awready;
  logic [IN_ID_W-1:0]  s_awid;
  logic [OUT_ID_W-1:0] m_awid;
  logic                m_rvalid, m_rready, m_rlast, s_rvalid, s_rready, s_rlast;
  logic [OUT_ID_W-1:0] m_rid;
  logic [IN_ID_W-1:0]  s_rid;
  logic                m_bvalid, m_bready, s_bvalid, s_bready;
  logic [OUT_ID_W-1:0] m_bid;
  logic [IN_ID_W-1:0]  s_bid;
  logic                err_resp, rd_busy, wr_busy;

  axi4_id_remapper #(
    .IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .SLOTS(SLOTS), .MAX_OUT(MAX_OUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rlast(s_rlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
    .err_resp(err_resp), .rd_busy(rd_busy), .wr_busy(wr_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=0x%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic idle();
    s_arvalid = 1'b0; s_arid = '0;
    s_awvalid = 1'b0; s_awid = '0;
    m_rvalid  = 1'b0; m_rid  = '0; m_rlast = 1'b0;
    m_bvalid  = 1'b0; m_bid  = '0;
    m_arready = 1'b1; m_awready = 1'b1;
    s_rready  = 1'b1; s_bready  = 1'b1;
  endtask

  // Next negedge with all channels idle, then settle.
  task automatic settle();
    @(negedge CLK);
    idle();
    #1;
  endtask

  task automatic ar_issue(input logic [15:0] id, input int idx);
    @(negedge CLK);
    idle();
    s_arvalid = 1'b1; s_arid = id;
    exp_q.push_back(32'(idx));
    #1;
    chk("ar_s_ready", s_arready, 1);
    chk("ar_m_valid", m_arvalid, 1);
    sb_chk("ar_m_id", m_arid);
  endtask

  task automatic aw_issue(input logic [15:0] id, input int idx);
    @(negedge CLK);
    idle();
    s_awvalid = 1'b1; s_awid = id;
    exp_q.push_back(32'(idx));
    #1;
    chk("aw_s_ready", s_awready, 1);
    chk("aw_m_valid", m_awvalid, 1);
    sb_chk("aw_m_id", m_awid);
  endtask

  task automatic r_beat(input int rid, input logic last, input logic [15:0] exp_id);
    @(negedge CLK);
    idle();
    m_rvalid = 1'b1; m_rid = OUT_ID_W'(rid); m_rlast = last;
    exp_q.push_back(32'(exp_id));
    #1;
    chk("r_s_valid", s_rvalid, 1);
    chk("r_m_ready", m_rready, 1);
    chk("r_s_last", s_rlast, last);
    sb_chk("r_s_id", s_rid);
  endtask

  task automatic b_beat(input int bid, input logic [15:0] exp_id);
    @(negedge CLK);
    idle();
    m_bvalid = 1'b1; m_bid = OUT_ID_W'(bid);
    exp_q.push_back(32'(exp_id));
    #1;
    chk("b_s_valid", s_bvalid, 1);
    chk("b_m_ready", m_bready, 1);
    sb_chk("b_s_id", s_bid);
  endtask

  initial begin
    RST_N = 1'b0;
    idle();
    s_arvalid = 1'b1; s_arid = 16'h5555;
    s_awvalid = 1'b1; s_awid = 16'h5555;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_s_arready", s_arready, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_s_awready", s_awready, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_err_resp", err_resp, 0);
    @(negedge CLK);
    idle();
    RST_N = 1'b1;

    // Same ID twice shares slot 0; two last beats drain it.
    ar_issue(16'h1234, 0);
    ar_issue(16'h1234, 0);
    settle();
    chk("t1_busy_2", rd_busy, 1);
    r_beat(0, 1'b1, 16'h1234);
    settle();
    chk("t1_busy_1", rd_busy, 1);
    r_beat(0, 1'b1, 16'h1234);
    settle();
    chk("t1_busy_0", rd_busy, 0);

    // Fill all read slots, then a 9th ID stalls until a slot frees.
    for (int i = 0; i < SLOTS; i++) ar_issue(16'hA000 + 16'(i), i);
    @(negedge CLK);
    idle();
    s_arvalid = 1'b1; s_arid = 16'hB000;
    #1;
    chk("t2_full_ready", s_arready, 0);
    chk("t2_full_valid", m_arvalid, 0);
    @(negedge CLK);
    m_rvalid = 1'b1; m_rid = 6'd3; m_rlast = 1'b1;
    exp_q.push_back(32'h0000A003);
    #1;
    chk("t2_release_cycle_ready", s_arready, 0);
    sb_chk("t2_release_rid", s_rid);
    @(negedge CLK);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    exp_q.push_back(32'd3);
    #1;
    chk("t2_after_ready", s_arready, 1);
    sb_chk("t2_after_arid", m_arid);
    for (int i = 0; i < SLOTS; i++)
      r_beat(i, 1'b1, (i == 3) ? 16'hB000 : 16'hA000 + 16'(i));
    settle();
    chk("t2_busy_0", rd_busy, 0);

    // One write ID up to MAX_OUT outstanding, then a B unblocks it.
    for (int i = 0; i < MAX_OUT; i++) aw_issue(16'h0777, 0);
    @(negedge CLK);
    idle();
    s_awvalid = 1'b1; s_awid = 16'h0777;
    m_bvalid = 1'b1; m_bid = 6'd0;
    exp_q.push_back(32'h00000777);
    #1;
    chk("t3_max_ready", s_awready, 0);
    chk("t3_max_valid", m_awvalid, 0);
    sb_chk("t3_b_id", s_bid);
    @(negedge CLK);
    m_bvalid = 1'b0;
    exp_q.push_back(32'd0);
    #1;
    chk("t3_unblock_ready", s_awready, 1);
    sb_chk("t3_unblock_awid", m_awid);
    for (int i = 0; i < MAX_OUT; i++) b_beat(0, 16'h0777);
    settle();
    chk("t3_wr_busy_0", wr_busy, 0);
    chk("t3_err_clear", err_resp, 0);

    // Allocate hit and release on slot 2 in the same cycle.
    ar_issue(16'h0100, 0);
    ar_issue(16'h0101, 1);
    ar_issue(16'h2222, 2);
    @(negedge CLK);
    idle();
    s_arvalid = 1'b1; s_arid = 16'h2222;
    m_rvalid = 1'b1; m_rid = 6'd2; m_rlast = 1'b1;
    exp_q.push_back(32'd2);
    exp_q.push_back(32'h00002222);
    #1;
    chk("t4_same_ready", s_arready, 1);
    sb_chk("t4_same_arid", m_arid);
    sb_chk("t4_same_rid", s_rid);
    r_beat(2, 1'b0, 16'h2222);
    r_beat(2, 1'b1, 16'h2222);
    ar_issue(16'h3333, 2);
    r_beat(2, 1'b1, 16'h3333);
    r_beat(0, 1'b1, 16'h0100);
    r_beat(1, 1'b1, 16'h0101);
    settle();
    chk("t4_busy_0", rd_busy, 0);
    chk("t4_err_clear", err_resp, 0);

    // Responses to idle or out-of-range slots.
    b_beat(5, 16'h0000);
    settle();
    chk("t5_err_set", err_resp, 1);
    r_beat(9, 1'b1, 16'h0000);
    settle();
    chk("t5_err_sticky", err_resp, 1);
    chk("t5_wr_busy", wr_busy, 0);

    // Reset mid-flight clears everything immediately.
    ar_issue(16'h0011, 0);
    ar_issue(16'h0012, 1);
    ar_issue(16'h0013, 2);
    settle();
    chk("t6_busy_pre", rd_busy, 1);
    @(negedge CLK);
    idle();
    RST_N = 1'b0;
    s_arvalid = 1'b1; s_arid = 16'h0099;
    #1;
    chk("t6_rst_busy", rd_busy, 0);
    chk("t6_rst_err", err_resp, 0);
    chk("t6_rst_ready", s_arready, 0);
    chk("t6_rst_valid", m_arvalid, 0);
    @(negedge CLK);
    idle();
    RST_N = 1'b1;
    s_arvalid = 1'b1; s_arid = 16'h0042;
    exp_q.push_back(32'd0);
    #1;
    chk("t6_first_ready", s_arready, 1);
    sb_chk("t6_first_arid", m_arid);
    r_beat(1, 1'b1, 16'h0000);
    settle();
    chk("t6_stale_err", err_resp, 1);
    r_beat(0, 1'b1, 16'h0042);
    settle();
    chk("t6_busy_end", rd_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_id_remapper.md
# axi4_id_remapper

Parametrised AXI4 ID compressor placed between the AWSteria HW core's wide-ID memory master (16-bit IDs) and a narrow-ID slave such as a DDR controller (6-bit IDs). It replaces plain truncation of ID bits with a tracked remap table. Distinct wide IDs that are in flight at the same time therefore never alias on the narrow side, and every response carries its original wide ID on return. Only the ID, valid, ready and last signals pass through this block. The parent routes all other AR/AW/W/R/B payload in parallel, and the W channel bypasses the block entirely.

## Interface
Parameters:
- IN_ID_W, 16, width of master-side (S) IDs
- OUT_ID_W, 6, width of slave-side (M) IDs
- SLOTS, 8, remap entries per direction (read and write tables are separate); SLOTS <= 2**OUT_ID_W
- MAX_OUT, 15, maximum outstanding transactions per slot; counter width is CW = clog2(MAX_OUT+1)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  reset, asynchronous and active-low
- s_arvalid / s_arready  in / out  1  master-side AR handshake
- s_arid  in  IN_ID_W  master-side read ID
- m_arvalid / m_arready  out / in  1  slave-side AR handshake
- m_arid  out  OUT_ID_W  allocated slot index, zero-extended
- s_awvalid, s_awready, s_awid, m_awvalid, m_awready, m_awid  same as the AR signals, for AW
- m_rvalid / m_rready  in / out  1  slave-side R handshake
- m_rid  in  OUT_ID_W  slave-side read response ID
- m_rlast  in  1  last beat of a read burst
- s_rvalid / s_rready  out / in  1  master-side R handshake
- s_rid  out  IN_ID_W  restored wide read ID
- s_rlast  out  1  equal to m_rlast
- m_bvalid, m_bready, m_bid, s_bvalid, s_bready, s_bid  same as the R signals, for B (no last)
- err_resp  out  1  sticky flag: a response arrived for a slot with count 0, or m_rid/m_bid >= SLOTS
- rd_busy / wr_busy  out  1  at least one read / write slot has count != 0

## Operation
- Each table entry holds a registered tag[IN_ID_W] and cnt[CW]. An entry is free when cnt == 0.
- Allocation is decided from registered state only, and is evaluated independently for AR and AW:
  - Hit: some entry has cnt != 0 and tag == s_xid. That entry is selected, which preserves AXI same-ID ordering. If its cnt == MAX_OUT, the channel stalls.
  - Miss: the lowest-indexed free entry is selected. If there is none, the channel stalls.
- m_xvalid = s_xvalid & ok & RST_N; s_xready = m_xready & ok & RST_N; m_xid = selected index. The AR/AW path is combinational.
- On an AR/AW handshake: the entry's cnt increments; on a miss, the tag is written with s_xid.
- R path is a combinational pass-through: s_rvalid = m_rvalid, m_rready = s_rready, s_rid = tag[m_rid]. The entry's cnt decrements on a handshake with m_rlast = 1.
- B path works the same way, decrementing on every B handshake.
- If allocation and release hit the same entry in one cycle, cnt is unchanged and the tag is kept.
- An entry whose cnt reaches 0 in cycle N is allocatable as a miss only from cycle N+1.
- Erroneous response (cnt == 0 or index >= SLOTS): the response still passes through, s_rid/s_bid = 0, no counter changes, and err_resp is set.

## Timing
- Reset (RST_N low, any time, including mid-burst): all cnt = 0, tags = 0, err_resp = 0, rd_busy = wr_busy = 0. s_arready, s_awready, m_arvalid and m_awvalid are forced to 0 while reset is asserted.
- Responses to pre-reset transactions that arrive after reset are flagged via err_resp.
- Zero added latency on every channel. Table updates become visible the cycle after the handshake.
- rd_busy and wr_busy are decoded from registered counts.

## Test plan
- AR s_arid=0x1234, then 0x1234 again, with m_arready=1 → both issue m_arid=0; cnt[0] goes 1 then 2. R with m_rid=0 and m_rlast=1 returns s_rid=0x1234 twice; rd_busy drops the cycle after the second last beat.
- AR with IDs 0xA000..0xA007 (SLOTS=8) → m_arid=0..7. A 9th ID 0xB000 is held with s_arready=0 until any R last beat frees a slot; the next cycle it issues into the lowest freed index.
- The same AW ID issued 15 times without B → the 16th stalls (s_awready=0). One B on that slot → the 16th issues the next cycle.
- Same cycle: an AR hit on slot 2 plus an R last beat on slot 2 → cnt[2] unchanged, tag kept; a subsequent R still returns the original ID.
- B with m_bid=5 while cnt[5]=0 → s_bvalid follows m_bvalid, s_bid=0, err_resp=1 and stays set until reset.
- RST_N asserted with 3 reads outstanding → all counts 0 immediately; after release, a new AR 0x0042 gets m_arid=0 in the first cycle.
